// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package seq_det_pkg;

  // Detector state encoding, also exposed on the debug port
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_HUNT = 2'b10
  } state_t;

  // Width needed to hold a pattern length in the range 0..max_len
  function automatic int LEN_W(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag and clear priority.
// Latency: count and flag update at the edge that samples inc/clr.
// Backpressure: none; every inc is counted until the counter saturates.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Clear wins over increment; the count holds at all-ones, and the flag
  // is raised as soon as the count reaches all-ones and stays until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX || cnt == CNT_MAX - 1'b1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern/length and overlap mode.
// Latency: match is registered, high the cycle after the completing bit's edge.
// Backpressure: none; bits are taken whenever bit_valid is high and state is not IDLE.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN         = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
  parameter int                 DEFAULT_LEN     = 4,
  parameter bit                 OVERLAP         = 1'b1,
  parameter int                 CNT_W           = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [LEN_W(MAX_LEN)-1:0]    cfg_len,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  input  logic                         clr_cnt,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat,
  output logic [1:0]                   state
);

  localparam int            LW        = LEN_W(MAX_LEN);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] DEF_LEN_L = LW'(DEFAULT_LEN);

  state_t             st_q, st_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [MAX_LEN-1:0] pattern_q, len_mask;
  logic [MAX_LEN:0]   hist_cat;
  logic [LW-1:0]      fill_q, fill_d, fill_next, len_q;
  logic               accept, hit, cfg_ok;

  // Mask selecting the active pattern bits [len-1:0]
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len_q) len_mask[i] = 1'b1;
    end
  end

  // Bit acceptance, match detection and next-state / history update
  always_comb begin
    st_d       = st_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    accept     = en && bit_valid && (st_q != ST_IDLE);
    hist_cat   = {hist_q, bit_in};
    hist_shift = hist_cat[MAX_LEN-1:0];
    fill_next  = (fill_q == len_q) ? len_q : fill_q + 1'b1;
    // The oldest history bit never lines up with the pattern, so it is masked off
    hit = accept && (fill_next == len_q) &&
          (((hist_cat ^ {1'b0, pattern_q}) & {1'b0, len_mask}) == '0);

    if (!en) begin
      st_d   = ST_IDLE;
      hist_d = '0;
      fill_d = '0;
    end else if (st_q == ST_IDLE) begin
      st_d = ST_FILL;
    end else if (accept) begin
      hist_d = hist_shift;
      fill_d = fill_next;
      if (hit && !OVERLAP) begin
        st_d   = ST_FILL;
        hist_d = '0;
        fill_d = '0;
      end else if (fill_next == len_q) begin
        st_d = ST_HUNT;
      end
    end
  end

  // State, history and fill registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      st_q   <= st_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // New configuration is only taken while idle and with a legal length
  assign cfg_ok = cfg_load && (st_q == ST_IDLE) &&
                  (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

  // Pattern and length registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= DEFAULT_PATTERN;
      len_q     <= DEF_LEN_L;
    end else if (cfg_ok) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
    end
  end

  // Registered one-cycle match pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match <= 1'b0;
    else        match <= hit;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .clr   (clr_cnt),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

  assign state = st_q;

endmodule
